// File: rtl/fmul_pkg.sv
// Shared types and helpers for the FMUL writeback stage.
// Holds the retire FSM encoding and the result-zero test.
package fmul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } state_e;

  localparam int REG_R0 = 0;

  function automatic logic is_zero16(input logic [15:0] v);
    return (v == 16'h0000);
  endfunction

endpackage

// File: rtl/fmul_writeback.sv
// FMUL result writeback: retires {r1,r0} through one 8-bit port
// over two cycles, then updates C/Z and counts the operation.
module fmul_writeback
  import fmul_pkg::*;
#(
  parameter int DST_LO = REG_R0,
  parameter int AW     = 5,
  parameter int CNT_W  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [7:0]       i_r1,
  input  logic [7:0]       i_r0,
  input  logic             i_c,
  input  logic             i_hold,
  output logic             o_we,
  output logic [AW-1:0]    o_waddr,
  output logic [7:0]       o_wdata,
  output logic             o_sreg_we,
  output logic             o_flag_c,
  output logic             o_flag_z,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_op_cnt
);

  localparam logic [AW-1:0] A_LO = AW'(DST_LO);
  localparam logic [AW-1:0] A_HI = A_LO + 1'b1;

  state_e           state_q, state_d;
  logic [7:0]       r1_q, r1_d;
  logic [7:0]       r0_q, r0_d;
  logic             c_q, c_d;
  logic             z_q, z_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  assign o_ready = i_rst_n && !i_hold &&
                   (state_q == IDLE || state_q == WR_HI);
  assign accept  = i_valid && o_ready;

  always_comb begin
    state_d = state_q;
    r1_d    = r1_q;
    r0_d    = r0_q;
    c_d     = c_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = WR_LO;
      end
      WR_LO: begin
        if (!i_hold) state_d = WR_HI;
      end
      WR_HI: begin
        if (!i_hold) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = accept ? WR_LO : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      r1_d = i_r1;
      r0_d = i_r0;
      c_d  = i_c;
      z_d  = is_zero16({i_r1, i_r0});
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      r1_q    <= '0;
      r0_q    <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      r1_q    <= r1_d;
      r0_q    <= r0_d;
      c_q     <= c_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes come from registered state/capture; hold only masks them.
  always_comb begin
    o_we      = 1'b0;
    o_waddr   = '0;
    o_wdata   = '0;
    o_sreg_we = 1'b0;
    o_flag_c  = 1'b0;
    o_flag_z  = 1'b0;
    unique case (state_q)
      WR_LO: begin
        o_we    = !i_hold;
        o_waddr = A_LO;
        o_wdata = r0_q;
      end
      WR_HI: begin
        o_we      = !i_hold;
        o_waddr   = A_HI;
        o_wdata   = r1_q;
        o_sreg_we = !i_hold;
        o_flag_c  = c_q;
        o_flag_z  = z_q;
      end
      default: ;
    endcase
  end

  assign o_busy   = (state_q != IDLE);
  assign o_op_cnt = cnt_q;

endmodule

// File: tb/tb_fmul_writeback.sv
// Directed self-checking bench for fmul_writeback.
// A 2-bit-counter instance shares the stimulus to exercise wrap.
module tb_fmul_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [7:0]  r1, r0;
  logic        c;
  logic        hold;

  logic        ready, we, sreg_we, fc, fz, busy;
  logic [4:0]  waddr;
  logic [7:0]  wdata;
  logic [15:0] cnt;

  logic        w_ready, w_we, w_sreg_we, w_fc, w_fz, w_busy;
  logic [4:0]  w_waddr;
  logic [7:0]  w_wdata;
  logic [1:0]  w_cnt;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fmul_writeback dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_valid(valid), .o_ready(ready),
    .i_r1(r1), .i_r0(r0), .i_c(c),
    .i_hold(hold), .o_we(we),
    .o_waddr(waddr), .o_wdata(wdata),
    .o_sreg_we(sreg_we), .o_flag_c(fc),
    .o_flag_z(fz), .o_busy(busy),
    .o_op_cnt(cnt)
  );

  fmul_writeback #(.CNT_W(2)) dut_w (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_valid(valid), .o_ready(w_ready),
    .i_r1(r1), .i_r0(r0), .i_c(c),
    .i_hold(hold), .o_we(w_we),
    .o_waddr(w_waddr), .o_wdata(w_wdata),
    .o_sreg_we(w_sreg_we), .o_flag_c(w_fc),
    .o_flag_z(w_fz), .o_busy(w_busy),
    .o_op_cnt(w_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag,
                        input logic [4:0] a,
                        input logic [7:0] d);
    chk({tag, ".we"}, 32'(we), 32'd1);
    chk({tag, ".addr"}, 32'(waddr), 32'(a));
    chk({tag, ".data"}, 32'(wdata), 32'(d));
  endtask

  task automatic chk_hi(input string tag,
                        input logic [7:0] d,
                        input logic ec,
                        input logic ez);
    chk_wr(tag, 5'd1, d);
    chk({tag, ".sreg_we"}, 32'(sreg_we), 32'd1);
    chk({tag, ".c"}, 32'(fc), 32'(ec));
    chk({tag, ".z"}, 32'(fz), 32'(ez));
  endtask

  task automatic present(input logic [7:0] h,
                         input logic [7:0] l,
                         input logic cc);
    valid = 1'b1;
    r1 = h;
    r0 = l;
    c = cc;
  endtask

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    r1 = '0;
    r0 = '0;
    c = 1'b0;
    hold = 1'b0;
    #12;
    chk("rst.ready", 32'(ready), 32'd0);
    chk("rst.we", 32'(we), 32'd0);
    chk("rst.sreg_we", 32'(sreg_we), 32'd0);
    chk("rst.addr", 32'(waddr), 32'd0);
    chk("rst.data", 32'(wdata), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.cnt", 32'(cnt), 32'd0);
    rst_n = 1'b1;
    #4;
    chk("rel.ready", 32'(ready), 32'd1);

    // 0x80*0x80
    present(8'h80, 8'h00, 1'b0);
    step();
    valid = 1'b0;
    chk("t1.busy", 32'(busy), 32'd1);
    chk("t1.lo.sreg", 32'(sreg_we), 32'd0);
    chk_wr("t1.lo", 5'd0, 8'h00);
    step();
    chk_hi("t1.hi", 8'h80, 1'b0, 1'b0);
    step();
    chk("t1.idle.we", 32'(we), 32'd0);
    chk("t1.idle.busy", 32'(busy), 32'd0);
    chk("t1.cnt", 32'(cnt), 32'd1);

    // 0x80*0x00 -> zero result
    present(8'h00, 8'h00, 1'b0);
    step();
    valid = 1'b0;
    chk_wr("t2.lo", 5'd0, 8'h00);
    step();
    chk_hi("t2.hi", 8'h00, 1'b0, 1'b1);
    step();
    chk("t2.cnt", 32'(cnt), 32'd2);
    chk("t2.wcnt", 32'(w_cnt), 32'd2);

    // back-to-back: 0x40*0x40 then 0x01*0x01
    chk("b2b.idle.ready", 32'(ready), 32'd1);
    present(8'h20, 8'h00, 1'b0);
    step();
    present(8'h00, 8'h02, 1'b0);
    chk("b2b.lo.ready", 32'(ready), 32'd0);
    chk_wr("b2b.w0", 5'd0, 8'h00);
    step();
    chk("b2b.hi.ready", 32'(ready), 32'd1);
    chk_hi("b2b.w1", 8'h20, 1'b0, 1'b0);
    step();
    valid = 1'b0;
    chk_wr("b2b.w2", 5'd0, 8'h02);
    step();
    chk("b2b.hi2.ready", 32'(ready), 32'd1);
    chk_hi("b2b.w3", 8'h00, 1'b0, 1'b0);
    step();
    chk("b2b.cnt", 32'(cnt), 32'd4);
    chk("wrap.wcnt", 32'(w_cnt), 32'd0);
    chk("b2b.busy", 32'(busy), 32'd0);

    // 0xFF*0xFF with 3-cycle hold in WR_LO
    present(8'hFC, 8'h02, 1'b1);
    step();
    valid = 1'b0;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold.we", 32'(we), 32'd0);
      chk("hold.addr", 32'(waddr), 32'd0);
      chk("hold.data", 32'(wdata), 32'h02);
      chk("hold.ready", 32'(ready), 32'd0);
      chk("hold.busy", 32'(busy), 32'd1);
      if (i < 2) step();
    end
    @(posedge clk);
    #1;
    hold = 1'b0;
    #1;
    chk_wr("hold.lo", 5'd0, 8'h02);
    step();
    chk_hi("hold.hi", 8'hFC, 1'b1, 1'b0);
    step();
    chk("hold.cnt", 32'(cnt), 32'd5);

    // 0x40*0xC0, reset during WR_LO
    present(8'h60, 8'h00, 1'b0);
    step();
    valid = 1'b0;
    chk_wr("ar.lo", 5'd0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.we", 32'(we), 32'd0);
    chk("ar.busy", 32'(busy), 32'd0);
    chk("ar.cnt", 32'(cnt), 32'd0);
    chk("ar.ready", 32'(ready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("ar.held.we", 32'(we), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ar.rel.ready", 32'(ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ar.nohi.we", 32'(we), 32'd0);
      chk("ar.nohi.sreg", 32'(sreg_we), 32'd0);
    end
    chk("ar.end.cnt", 32'(cnt), 32'd0);
    chk("ar.end.busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
